// File: rtl/ntt_pkg.sv
// Shared NTT arithmetic types and constants: default modulus, coefficient type,
// butterfly mode encoding and Barrett reduction constants.
package ntt_pkg;

  localparam int WIDTH = 23;
  localparam int Q     = 8380417;

  typedef logic [WIDTH-1:0] coeff_t;

  typedef enum logic {
    BF_CT = 1'b0,
    BF_GS = 1'b1
  } bf_mode_e;

  // mu = floor(2**(2*w) / q); evaluated at elaboration time only
  function automatic logic [63:0] barrett_mu(input int w, input int q);
    logic [64:0] num;
    num = 65'd1 << (2 * w);
    return 64'(num / 65'(q));
  endfunction

  localparam int          BARRETT_SHIFT = 2 * WIDTH;
  localparam logic [63:0] BARRETT_MU    = barrett_mu(WIDTH, Q);

endpackage

// File: rtl/mod_reduce.sv
// Combinational Barrett reduction of a 2*WIDTH-bit value (< Q**2) into [0,Q).
// The quotient estimate is at most one short, so a single conditional subtract suffices.
module mod_reduce #(
  parameter int WIDTH = ntt_pkg::WIDTH,
  parameter int Q     = ntt_pkg::Q
) (
  input  logic [2*WIDTH-1:0] x,
  output logic [WIDTH-1:0]   y
);
  import ntt_pkg::*;

  localparam logic [63:0]     MU   = barrett_mu(WIDTH, Q);
  localparam int              MUW  = $clog2(MU + 64'd1);
  localparam int              PW   = 2 * WIDTH + MUW;
  localparam logic [PW-1:0]   MU_P = PW'(MU);
  localparam logic [WIDTH:0]  Q_R  = (WIDTH + 1)'(Q);

  logic [MUW-1:0] qhat;
  logic [WIDTH:0] qq;
  logic [WIDTH:0] r;

  assign qhat = MUW'((PW'(x) * MU_P) >> (2 * WIDTH));
  // x - qhat*Q < 2Q, so only the low WIDTH+1 bits of the difference matter
  assign qq   = (WIDTH + 1)'(qhat) * Q_R;
  assign r    = x[WIDTH:0] - qq;
  assign y    = (r >= Q_R) ? WIDTH'(r - Q_R) : r[WIDTH-1:0];

endmodule

// File: rtl/butterfly_pipe.sv
// Four-stage CT/GS NTT butterfly mod Q, one op per cycle, fixed latency 4.
// A single enable stalls every stage whenever the output is valid but not taken.
module butterfly_pipe #(
  parameter int WIDTH = ntt_pkg::WIDTH,
  parameter int Q     = ntt_pkg::Q
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] twiddle_i,
  input  logic             sel_red_i,
  input  logic             sel_butterfly_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             busy_o
);
  import ntt_pkg::*;

  typedef logic [WIDTH-1:0] word_t;
  localparam logic [WIDTH:0] QX = (WIDTH + 1)'(Q);

  function automatic word_t add_q(input word_t x, input word_t y);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= QX) ? WIDTH'(s - QX) : s[WIDTH-1:0];
  endfunction

  function automatic word_t sub_q(input word_t x, input word_t y);
    logic [WIDTH:0] d;
    d = {1'b0, x} - {1'b0, y};
    return (x < y) ? WIDTH'(d + QX) : d[WIDTH-1:0];
  endfunction

  logic                 en;
  logic                 v1, v2, v3;
  bf_mode_e             m1, m2, m3;
  logic                 red1;
  word_t                a1, s1, x1, w1;
  word_t                a2, s2;
  logic [2*WIDTH-1:0]   p2;
  word_t                a3, s3, r3;
  word_t                r_red;

  assign en      = !valid_o || ready_i;
  assign ready_o = en;
  assign busy_o  = v1 || v2 || v3 || valid_o;

  mod_reduce #(.WIDTH(WIDTH), .Q(Q)) u_reduce (
    .x (p2),
    .y (r_red)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; valid_o <= 1'b0;
      m1 <= BF_CT; m2 <= BF_CT; m3 <= BF_CT; red1 <= 1'b0;
      a1 <= '0; s1 <= '0; x1 <= '0; w1 <= '0;
      a2 <= '0; s2 <= '0; p2 <= '0;
      a3 <= '0; s3 <= '0; r3 <= '0;
      a_o <= '0; b_o <= '0;
    end else if (en) begin
      // S1: GS pre-add/sub; CT feeds b straight to the multiplier
      v1   <= valid_i;
      m1   <= bf_mode_e'(sel_butterfly_i);
      red1 <= sel_red_i;
      a1   <= a_i;
      w1   <= twiddle_i;
      s1   <= add_q(a_i, b_i);
      x1   <= sel_butterfly_i ? sub_q(a_i, b_i) : b_i;
      // S2: full-width product, or pass-through when the twiddle is bypassed
      v2 <= v1; m2 <= m1; a2 <= a1; s2 <= s1;
      p2 <= red1 ? (2 * WIDTH)'(x1) * (2 * WIDTH)'(w1) : (2 * WIDTH)'(x1);
      // S3: Barrett reduction
      v3 <= v2; m3 <= m2; a3 <= a2; s3 <= s2;
      r3 <= r_red;
      // S4: final combine into the output register
      valid_o <= v3;
      if (m3 == BF_GS) begin
        a_o <= s3;
        b_o <= r3;
      end else begin
        a_o <= add_q(a3, r3);
        b_o <= sub_q(a3, r3);
      end
    end
  end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed-vector and scoreboard bench for butterfly_pipe (Q = 8380417).
module tb_butterfly_pipe;
  localparam int W = 23;
  localparam int Q = 8380417;

  typedef struct packed {
    logic [W-1:0] a, b, w;
    logic         red, gs;
  } op_t;
  typedef struct packed {
    logic [W-1:0] ea, eb;
  } exp_t;
  typedef struct packed {
    op_t  op;
    exp_t e;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_i, valid_i, ready_o, sel_red_i, sel_butterfly_i, valid_o, ready_i, busy_o;
  logic [W-1:0] a_i, b_i, twiddle_i, a_o, b_o;

  int   checks = 0;
  int   failures = 0;
  int   n_out = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  butterfly_pipe #(.WIDTH(W), .Q(Q)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .twiddle_i(twiddle_i), .sel_red_i(sel_red_i),
    .sel_butterfly_i(sel_butterfly_i), .valid_o(valid_o), .ready_i(ready_i),
    .a_o(a_o), .b_o(b_o), .busy_o(busy_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t gold(input op_t op);
    longint unsigned a, b, w, t, d;
    exp_t e;
    a = op.a; b = op.b; w = op.red ? op.w : 1;
    if (op.gs) begin
      d    = (a + Q - b) % Q;
      e.ea = W'((a + b) % Q);
      e.eb = W'((d * w) % Q);
    end else begin
      t    = (b * w) % Q;
      e.ea = W'((a + t) % Q);
      e.eb = W'((a + Q - t) % Q);
    end
    return e;
  endfunction

  function automatic vec_t mk(input int a, input int b, input int w, input bit red, input bit gs,
                              input int ea, input int eb);
    vec_t v;
    v.op.a = W'(a); v.op.b = W'(b); v.op.w = W'(w); v.op.red = red; v.op.gs = gs;
    v.e.ea = W'(ea); v.e.eb = W'(eb);
    return v;
  endfunction

  function automatic logic [W-1:0] rand_val();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return W'(Q - 1);
    if (sel == 1) return '0;
    return W'($urandom_range(0, Q - 1));
  endfunction

  // One cycle: drive, settle, score the output side, then cross the clock edge.
  task automatic step(input bit v, input bit rdy, input op_t op, input exp_t e, output bit acc);
    valid_i = v; ready_i = rdy;
    a_i = op.a; b_i = op.b; twiddle_i = op.w; sel_red_i = op.red; sel_butterfly_i = op.gs;
    #1;
    check("ready_o", ready_o, !valid_o || rdy);
    if (valid_o === 1'b1) begin
      check("out_expected", sbq.size() > 0, 1);
      if (sbq.size() > 0) begin
        check("a_o", a_o, sbq[0].ea);
        check("b_o", b_o, sbq[0].eb);
        if (rdy) begin
          void'(sbq.pop_front());
          n_out++;
        end
      end
    end
    acc = v && (ready_o === 1'b1);
    if (acc) sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    ready_i = 1'b0;
    #1;
    check({tag, "_valid_o"}, valid_o, 0);
    check({tag, "_busy_o"}, busy_o, 0);
    check({tag, "_ready_o"}, ready_o, 1);
    check({tag, "_a_o"}, a_o, 0);
    check({tag, "_b_o"}, b_o, 0);
  endtask

  task automatic drain(input string tag, input int expect_out, input int base_out);
    bit acc;
    int guard = 0;
    while (sbq.size() > 0 && guard < 200) begin
      step(1'b0, 1'b1, '0, '0, acc);
      guard++;
    end
    check({tag, "_drained"}, sbq.size(), 0);
    check({tag, "_count"}, n_out - base_out, expect_out);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    op_t  ops[10];
    bit   acc;
    int   i, cyc, base;

    vecs[0] = mk(1, 2, 3, 1, 0, 7, 8380412);
    vecs[1] = mk(5, 3, 4, 1, 1, 8, 8);
    vecs[2] = mk(8380416, 1, 1, 1, 0, 0, 8380415);
    vecs[3] = mk(0, 8380416, 8380416, 1, 0, 1, 8380416);
    vecs[4] = mk(10, 20, 12345, 0, 0, 30, 8380407);
    vecs[5] = mk(10, 20, 12345, 0, 1, 30, 8380407);
    vecs[6] = mk(8380416, 8380416, 2, 1, 1, 8380415, 0);
    vecs[7] = mk(0, 1, 8380416, 1, 1, 1, 1);
    vecs[8] = mk(100, 0, 777, 1, 0, 100, 100);

    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    a_i = '0; b_i = '0; twiddle_i = '0; sel_red_i = 1'b0; sel_butterfly_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    check_reset_state("reset");

    // Directed vectors, each checked for exact 4-cycle latency
    foreach (vecs[k]) begin
      step(1'b1, 1'b1, vecs[k].op, vecs[k].e, acc);
      check("vec_accepted", acc, 1);
      for (int c = 0; c < 3; c++) begin
        check("latency_not_yet", valid_o, 0);
        step(1'b0, 1'b1, '0, '0, acc);
      end
      check("latency_valid", valid_o, 1);
      step(1'b0, 1'b1, '0, '0, acc);
      check("vec_popped", sbq.size(), 0);
    end

    // Back-to-back mixed stream with a 3-cycle downstream stall
    for (int k = 0; k < 10; k++) begin
      ops[k].a = W'(1000 * k + 17); ops[k].b = W'(Q - 1 - 555 * k);
      ops[k].w = W'(31337 * (k + 1)); ops[k].red = (k != 4); ops[k].gs = k[0];
    end
    base = n_out; i = 0; cyc = 0;
    while (i < 10 && cyc < 100) begin
      step(1'b1, !(cyc >= 6 && cyc < 9), ops[i], gold(ops[i]), acc);
      if (cyc >= 6 && cyc < 9) check("stall_ready_low", ready_o, 0);
      if (acc) i++;
      cyc++;
    end
    check("stream_accepted", i, 10);
    drain("stream", 10, base);

    // Reset with three operations in flight
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, ops[k], gold(ops[k]), acc);
    rst_i = 1'b1; valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    check_reset_state("midrst");
    sbq.delete();
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, '0, '0, acc);
    check("midrst_no_stale", n_out, base + 10);

    // Random traffic with input gaps and downstream backpressure
    base = n_out; i = 0; cyc = 0;
    begin
      op_t op;
      bit  v;
      op = '0;
      while (i < 10000 && cyc < 40000) begin
        v = ($urandom_range(0, 9) < 7);
        if (v) begin
          op.a = rand_val(); op.b = rand_val(); op.w = rand_val();
          op.red = ($urandom_range(0, 5) != 0); op.gs = $urandom_range(0, 1) != 0;
        end
        step(v, $urandom_range(0, 3) != 0, op, gold(op), acc);
        if (acc) i++;
        cyc++;
      end
    end
    check("random_accepted", i, 10000);
    drain("random", 10000, base);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
